// File: rtl/jk_seq_driver_pkg.sv
// Shared types for the JK sequence driver: FSM state encoding and the J/K excitation table.
// JK_TOGGLE_PREF_EN selects toggle (J1 K1) for changing bits instead of set/reset.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Two bits {J,K} per entry, indexed by {q,target}: entry 0 = q0T0 ... entry 3 = q1T1.
`ifdef JK_TOGGLE_PREF_EN
  localparam logic [7:0] JK_ENC_TBL = {2'b00, 2'b11, 2'b11, 2'b00};
`else
  localparam logic [7:0] JK_ENC_TBL = {2'b00, 2'b01, 2'b10, 2'b00};
`endif

  function automatic logic [1:0] jk_encode(input logic q, input logic t);
    int idx;
    idx = 2 * int'({q, t});
    return JK_ENC_TBL[idx +: 2];
  endfunction

endpackage

// File: rtl/jk_seq_driver_if.sv
// Bus between the JK sequence driver (slave) and its producer/consumer (master).
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid holds until then.
interface jk_seq_driver_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  localparam int FW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_target;
  logic             hold;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic             res_valid;
  logic             res_ready;
  logic             res_ok;
  logic [FW-1:0]    res_flips;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output in_valid, in_target, hold, res_ready,
    input  in_ready, j, k, q, res_valid, res_ok, res_flips, err_cnt
  );

  modport slave (
    input  in_valid, in_target, hold, res_ready,
    output in_ready, j, k, q, res_valid, res_ok, res_flips, err_cnt
  );
endinterface

// File: rtl/jk_seq_driver_bank.sv
// Bank of WIDTH JK flip-flops sharing one update enable; async active-high reset clears it.
module jk_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] k_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j_i[i], k_i[i]})
          2'b01:   q_q[i] <= 1'b0;
          2'b10:   q_q[i] <= 1'b1;
          2'b11:   q_q[i] <= ~q_q[i];
          default: q_q[i] <= q_q[i];
        endcase
      end
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/jk_seq_driver.sv
// JK sequence driver: accepts a target vector, drives the JK bank once, checks and reports.
// JK_TOGGLE_PREF_EN (see jk_seq_pkg) changes only the J/K encoding, never the resulting Q.
module jk_seq_driver
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  jk_seq_driver_if.slave  bus,
  output state_e          state_o
);
  localparam int FW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, q_before_q, bank_q, j_w, k_w, diff_w;
  logic             res_ok_q;
  logic [FW-1:0]    res_flips_q, flips_w;
  logic [ERR_W-1:0] err_cnt_q;
  logic             in_ready_w, accept_w, bank_en_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_w) state_d = S_DRIVE;
      S_DRIVE: state_d = S_CHECK;
      S_CHECK: state_d = S_RESP;
      S_RESP:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready is gated by rst so nothing looks acceptable while reset is asserted.
  always_comb begin
    in_ready_w    = (state_q == S_IDLE) && !rst;
    accept_w      = bus.in_valid && in_ready_w;
    bank_en_w     = (state_q == S_DRIVE) && !bus.hold;
    bus.in_ready  = in_ready_w;
    bus.res_valid = (state_q == S_RESP);
  end

  always_comb begin
    j_w = '0;
    k_w = '0;
    if (state_q == S_DRIVE) begin
      for (int i = 0; i < WIDTH; i++) begin
        {j_w[i], k_w[i]} = jk_encode(bank_q[i], target_q[i]);
      end
    end
  end

  always_comb begin
    diff_w  = bank_q ^ q_before_q;
    flips_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flips_w = flips_w + FW'(diff_w[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q    <= '0;
      q_before_q  <= '0;
      res_ok_q    <= 1'b0;
      res_flips_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (accept_w) begin
        target_q   <= bus.in_target;
        q_before_q <= bank_q;
      end
      if (state_q == S_CHECK) begin
        res_ok_q    <= (bank_q == target_q);
        res_flips_q <= flips_w;
        if ((bank_q != target_q) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk  (clk),
    .rst  (rst),
    .en_i (bank_en_w),
    .j_i  (j_w),
    .k_i  (k_w),
    .q_o  (bank_q)
  );

  assign bus.j         = j_w;
  assign bus.k         = k_w;
  assign bus.q         = bank_q;
  assign bus.res_ok    = res_ok_q;
  assign bus.res_flips = res_flips_q;
  assign bus.err_cnt   = err_cnt_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_jk_seq_driver.sv
// Directed + randomized bench for jk_seq_driver against a bit-vector reference model.
module tb_jk_seq_driver;
  import jk_seq_pkg::*;

  localparam int W  = 4;
  localparam int EW = 8;

  logic   clk;
  logic   rst;
  state_e state;

  jk_seq_driver_if #(.WIDTH(W), .ERR_W(EW)) bus ();

  jk_seq_driver #(.WIDTH(W), .ERR_W(EW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0] mq;
  int           merr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input logic [W-1:0] t, input logic hv, input int delay);
    logic [W-1:0] qb, ej, ek;
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_target = t;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.hold     = hv;
    qb = mq;
`ifdef JK_TOGGLE_PREF_EN
    ej = t ^ qb;
    ek = t ^ qb;
`else
    ej = t & ~qb;
    ek = qb & ~t;
`endif
    check("drive_state", 32'(state), 32'(S_DRIVE));
    check("drive_j", 32'(bus.j), 32'(ej));
    check("drive_k", 32'(bus.k), 32'(ek));
    @(negedge clk);
    bus.hold = 1'b0;
    mq = hv ? qb : t;
    check("q_after_update", 32'(bus.q), 32'(mq));
    check("jk_zero_check", 32'({bus.j, bus.k}), 32'd0);
    @(negedge clk);
    if (mq != t && merr < 255) merr++;
    check("res_valid_up", 32'(bus.res_valid), 32'd1);
    check("res_ok", 32'(bus.res_ok), 32'(mq == t));
    check("res_flips", 32'(bus.res_flips), 32'($countones(mq ^ qb)));
    check("err_cnt", 32'(bus.err_cnt), 32'(merr));
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    for (int d = 0; d < delay; d++) begin
      bus.in_valid = (delay >= 5);
      @(negedge clk);
      check("resp_held_valid", 32'(bus.res_valid), 32'd1);
      check("resp_held_ok", 32'(bus.res_ok), 32'(mq == t));
      check("resp_held_flips", 32'(bus.res_flips), 32'($countones(mq ^ qb)));
      check("resp_no_accept", 32'(bus.in_ready), 32'd0);
      check("resp_state", 32'(state), 32'(S_RESP));
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_valid_drop", 32'(bus.res_valid), 32'd0);
    check("back_idle", 32'(state), 32'(S_IDLE));
    check("q_stable", 32'(bus.q), 32'(mq));
  endtask

  initial begin
    logic [W-1:0] t;
    logic         hv;
    int           d;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_target = '0;
    bus.hold      = 1'b0;
    bus.res_ready = 1'b0;
    mq            = '0;
    merr          = 0;

    repeat (2) @(negedge clk);
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_jk", 32'({bus.j, bus.k}), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_err", 32'(bus.err_cnt), 32'd0);
    check("rst_res_ok", 32'(bus.res_ok), 32'd0);
    rst = 1'b0;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    do_txn(4'b1010, 1'b0, 0);
    do_txn(4'b0110, 1'b0, 1);
    do_txn(4'b0110, 1'b0, 0);
    do_txn(4'b0011, 1'b0, 5);

    for (int i = 0; i < 24; i++) begin
      t  = W'($urandom_range(0, (1 << W) - 1));
      hv = ($urandom_range(0, 3) == 0);
      d  = $urandom_range(0, 3);
      do_txn(t, hv, d);
    end

    // Abort in CHECK: the pending result must never appear.
    bus.in_valid  = 1'b1;
    bus.in_target = ~mq;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("abort_in_check", 32'(state), 32'(S_CHECK));
    rst = 1'b1;
    #1;
    mq   = '0;
    merr = 0;
    check("abort_q", 32'(bus.q), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_state", 32'(state), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_release_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_result", 32'(bus.res_valid), 32'd0);
      check("abort_err", 32'(bus.err_cnt), 32'd0);
    end

    do_txn(4'b0110, 1'b0, 0);
    do_txn(4'b1111, 1'b1, 0);
    check("hold_err_one", 32'(bus.err_cnt), 32'd1);
    for (int i = 0; i < 256; i++) do_txn(4'b1111, 1'b1, 0);
    check("err_saturated", 32'(bus.err_cnt), 32'd255);
    check("hold_q_kept", 32'(bus.q), 32'(4'b0110));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "timeout");
  end
endmodule
